// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation blocks: water tank states and probe geometry.
package irrigation_pkg;

  localparam int unsigned PROBE_COUNT = 7;
  localparam int unsigned LEVEL_WIDTH = 3;

  typedef enum logic [1:0] {
    StNormal  = 2'd0,
    StFilling = 2'd1,
    StFault   = 2'd2
  } tank_state_e;

  // True when the vector is 0...01...1; all-zero counts as legal.
  function automatic logic is_thermometer(input logic [PROBE_COUNT-1:0] code);
    logic [PROBE_COUNT-1:0] code_inc;
    code_inc = code + PROBE_COUNT'(1);
    return (code & code_inc) == '0;
  endfunction

  // Number of set bits; only meaningful as a level for thermometer codes.
  function automatic logic [LEVEL_WIDTH-1:0] ones_count(input logic [PROBE_COUNT-1:0] code);
    logic [LEVEL_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < PROBE_COUNT; i++) begin
      acc = acc + LEVEL_WIDTH'(code[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/probe_debouncer.sv
// One water probe: 2-flop synchroniser, sample-tick debounce counter and debounced value.
module probe_debouncer #(
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_tick,
  input  logic probe,
  output logic debounced
);

  localparam logic [3:0] Threshold = 4'(DEBOUNCE_SAMPLES);

  logic       sync1_q, sync2_q;
  logic       deb_q, deb_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;

  // Synchroniser stages run every clock; debounce state only moves on ticks.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= probe;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count disagreeing ticks; flipping on the threshold clears the count so it never wraps.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 4'd1;
    if (sample_tick) begin
      if (sync2_q == deb_q) begin
        cnt_d = 4'd0;
      end else if (cnt_inc >= Threshold) begin
        deb_d = ~deb_q;
        cnt_d = 4'd0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  assign debounced = deb_q;

endmodule

// File: rtl/water_level_monitor.sv
// Water tank level monitor: debounces seven thermometer probes, validates the code,
// and derives the watering/filling conditions with fill hysteresis.
// Optional STICKY_FAULT_EN: a probe fault latches until reset.
module water_level_monitor
  import irrigation_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned DRY_MARK         = 1,
  parameter int unsigned LOW_MARK         = 2,
  parameter int unsigned HIGH_MARK        = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sample_tick,
  input  logic [PROBE_COUNT-1:0] probe,
  output logic [LEVEL_WIDTH-1:0] water_level,
  output logic                   watering_condition,
  output logic                   filling_condition,
  output logic                   probe_fault
);

  localparam logic [LEVEL_WIDTH-1:0] DryMark  = LEVEL_WIDTH'(DRY_MARK);
  localparam logic [LEVEL_WIDTH-1:0] LowMark  = LEVEL_WIDTH'(LOW_MARK);
  localparam logic [LEVEL_WIDTH-1:0] HighMark = LEVEL_WIDTH'(HIGH_MARK);

  logic [PROBE_COUNT-1:0] deb_vec;
  logic                   code_legal;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   fault_q, fault_d;
  tank_state_e            state_q, state_d;
  logic                   watering_q, watering_d;
  logic                   filling_q, filling_d;

  for (genvar g = 0; g < PROBE_COUNT; g++) begin : g_probe
    probe_debouncer #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_probe_debouncer (
      .clock      (clock),
      .reset      (reset),
      .sample_tick(sample_tick),
      .probe      (probe[g]),
      .debounced  (deb_vec[g])
    );
  end

  // Code check on the combined vector, so simultaneous flips never look illegal.
  always_comb begin
    code_legal = is_thermometer(deb_vec);
    level_d    = code_legal ? ones_count(deb_vec) : level_q;
`ifdef STICKY_FAULT_EN
    fault_d    = fault_q | ~code_legal;
`else
    fault_d    = ~code_legal;
`endif
  end

  // State register plus registered level, fault and condition outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q    <= '0;
      fault_q    <= 1'b0;
      state_q    <= StNormal;
      watering_q <= 1'b0;
      filling_q  <= 1'b0;
    end else begin
      level_q    <= level_d;
      fault_q    <= fault_d;
      state_q    <= state_d;
      watering_q <= watering_d;
      filling_q  <= filling_d;
    end
  end

  // Next state from the registered level/fault; fault overrides the mark comparisons.
  always_comb begin
    state_d = state_q;
    if (fault_q) begin
      state_d = StFault;
    end else begin
      unique case (state_q)
        StNormal:  if (level_q <= LowMark)  state_d = StFilling;
        StFilling: if (level_q >= HighMark) state_d = StNormal;
`ifdef STICKY_FAULT_EN
        StFault:   state_d = StFault;
`else
        // Leave FAULT unconditionally; marks are judged from the next cycle.
        StFault:   state_d = StNormal;
`endif
        default:   state_d = StNormal;
      endcase
    end
  end

  // Conditions derived from the next state so they land together with the state.
  always_comb begin
    filling_d  = (state_d == StFilling);
    watering_d = (state_d != StFault) && (level_q > DryMark);
  end

  assign water_level        = level_q;
  assign probe_fault        = fault_q;
  assign watering_condition = watering_q;
  assign filling_condition  = filling_q;

endmodule

// File: tb/tb_water_level_monitor.sv
// Directed, table-driven bench for water_level_monitor with default parameters.
module tb_water_level_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic [6:0] probe;
  logic [2:0] water_level;
  logic       watering_condition;
  logic       filling_condition;
  logic       probe_fault;

  int n_cmp = 0;
  int n_err = 0;

  water_level_monitor dut (
    .clock             (clock),
    .reset             (reset),
    .sample_tick       (sample_tick),
    .probe             (probe),
    .water_level       (water_level),
    .watering_condition(watering_condition),
    .filling_condition (filling_condition),
    .probe_fault       (probe_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [6:0] probe;
    logic [2:0] level;
    logic       fault;
    logic       water;
    logic       fill;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input logic [2:0] lvl, input logic flt,
                           input logic wat, input logic fil);
    check({name, ".level"}, int'(water_level), int'(lvl));
    check({name, ".fault"}, int'(probe_fault), int'(flt));
    check({name, ".water"}, int'(watering_condition), int'(wat));
    check({name, ".fill"}, int'(filling_condition), int'(fil));
  endtask

  // Change the raw probes and let them clear the synchroniser.
  task automatic set_probe(input logic [6:0] v);
    probe = v;
    repeat (3) @(negedge clock);
  endtask

  // One sample tick, followed by enough clocks for level and conditions to settle.
  task automatic do_tick();
    @(negedge clock) sample_tick = 1'b1;
    @(negedge clock) sample_tick = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic run_vec(input int i);
    set_probe(vecs[i].probe);
    repeat (5) do_tick();
    check_all(vecs[i].name, vecs[i].level, vecs[i].fault, vecs[i].water, vecs[i].fill);
  endtask

  initial begin
    vecs[0]  = '{"up1", 7'b0000001, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{"up2", 7'b0000011, 3'd2, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{"up3", 7'b0000111, 3'd3, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{"up4", 7'b0001111, 3'd4, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{"up5", 7'b0011111, 3'd5, 1'b0, 1'b1, 1'b1};
    // index 5..: after the hand-checked step to level 6
    vecs[5]  = '{"up7", 7'b1111111, 3'd7, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{"dn6", 7'b0111111, 3'd6, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{"dn5", 7'b0011111, 3'd5, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"dn4", 7'b0001111, 3'd4, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"dn3", 7'b0000111, 3'd3, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{"dn2", 7'b0000011, 3'd2, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{"dn1", 7'b0000001, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{"dn0", 7'b0000000, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{"flt_pre", 7'b0000001, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{"flt_bad", 7'b0000101, 3'd1, 1'b1, 1'b0, 1'b0};
`ifdef STICKY_FAULT_EN
    vecs[15] = '{"flt_fix", 7'b0000111, 3'd3, 1'b1, 1'b0, 1'b0};
`else
    vecs[15] = '{"flt_fix", 7'b0000111, 3'd3, 1'b0, 1'b1, 1'b0};
`endif

    // Reset, with a tick asserted that must be ignored.
    reset = 1'b1;
    sample_tick = 1'b1;
    probe = 7'b0000000;
    repeat (3) @(negedge clock);
    sample_tick = 1'b0;
    check_all("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check_all("rst_rel", 3'd0, 1'b0, 1'b0, 1'b1);

    // Glitch of 3 ticks on probe[0]: no change.
    set_probe(7'b0000001);
    repeat (3) do_tick();
    set_probe(7'b0000000);
    repeat (2) do_tick();
    check_all("glitch3", 3'd0, 1'b0, 1'b0, 1'b1);

    // 4-tick pulse: level flips one clock after the 4th tick.
    set_probe(7'b0000001);
    repeat (3) do_tick();
    @(negedge clock) sample_tick = 1'b1;
    @(negedge clock) sample_tick = 1'b0;
    check("p4.at_tick", int'(water_level), 0);
    @(negedge clock);
    check("p4.tick_p1", int'(water_level), 1);
    @(negedge clock);
    check_all("p4.settled", 3'd1, 1'b0, 1'b0, 1'b1);
    set_probe(7'b0000000);
    repeat (5) do_tick();
    check("p4.back", int'(water_level), 0);

    // Ramp up to level 5.
    for (int i = 0; i <= 4; i++) run_vec(i);

    // Level 6: filling drops two clocks after the 6th probe flips.
    set_probe(7'b0111111);
    repeat (3) do_tick();
    @(negedge clock) sample_tick = 1'b1;
    @(negedge clock) sample_tick = 1'b0;
    check("hi.t0.level", int'(water_level), 5);
    check("hi.t0.fill", int'(filling_condition), 1);
    @(negedge clock);
    check("hi.t1.level", int'(water_level), 6);
    check("hi.t1.fill", int'(filling_condition), 1);
    @(negedge clock);
    check("hi.t2.fill", int'(filling_condition), 0);
    check("hi.t2.water", int'(watering_condition), 1);

    // Rest of ramp, drain and fault sequence.
    for (int i = 5; i <= 15; i++) run_vec(i);

    // Reset mid-debounce discards a partial count.
    reset = 1'b1;
    set_probe(7'b0000000);
    reset = 1'b0;
    set_probe(7'b0000001);
    repeat (3) do_tick();
    @(negedge clock) begin reset = 1'b1; sample_tick = 1'b1; end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sample_tick = 1'b0;
    check_all("mid.rst", 3'd0, 1'b0, 1'b0, 1'b0);
    set_probe(7'b0000001);
    repeat (3) do_tick();
    check_all("mid.3tick", 3'd0, 1'b0, 1'b0, 1'b1);
    do_tick();
    check_all("mid.4tick", 3'd1, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/water_level_monitor.md
# water_level_monitor

Conditions the raw water-tank level probes and turns them into the tank level and the watering/filling conditions. It sits directly upstream of the water tank FSM, whose `watering_condition` and `filling_condition` inputs it drives. It also drives the 3-bit `water` level used by the matrix display. It synchronises and debounces seven thermometer-coded probes, detects illegal probe codes, and applies fill hysteresis.

## Interface
- `DEBOUNCE_SAMPLES`, default 4: consecutive disagreeing sample ticks needed before a probe's debounced value flips. Legal range 1..15.
- `DRY_MARK`, default 1: watering is allowed only while level > `DRY_MARK`.
- `LOW_MARK`, default 2: filling starts when level ≤ `LOW_MARK`.
- `HIGH_MARK`, default 6: filling stops when level ≥ `HIGH_MARK`.
- Parameter constraint: `DRY_MARK` < `LOW_MARK` < `HIGH_MARK` ≤ 7.
- `clock` input, 1 bit: the single clock, driven by the fast clock from the clock definer.
- `reset` input, 1 bit: synchronous, active-high.
- `sample_tick` input, 1 bit: one-cycle sample enable, e.g. the slow clock edge-detected upstream.
- `probe` input, 7 bits: raw asynchronous probes. `probe[0]` is the lowest; 1 means wet.
- `water_level` output, 3 bits: validated level, 0..7.
- `watering_condition` output, 1 bit: level is sufficient to water.
- `filling_condition` output, 1 bit: the tank must be filled.
- `probe_fault` output, 1 bit: the debounced probe code is not a thermometer code.

## Operation
- **Synchroniser:** a 2-flop synchroniser on each probe bit, clocked every cycle.
- **Debounce, per probe, only on cycles with `sample_tick`=1:**
  - Synchronised value equals the debounced value: counter cleared to 0.
  - Otherwise the counter increments.
  - When the counter reaches `DEBOUNCE_SAMPLES`, the debounced value flips and the counter clears in the same cycle.
  - Counter width is 4 bits. It never wraps, because flipping clears it.
- **Code check:** the debounced vector is legal only if it has the form 0…01…1 (all ones contiguous from bit 0); all-zero is legal.
  - Legal code: level = number of ones.
  - Illegal code: `water_level` holds its last legal value.
- **FSM states:** NORMAL, FILLING, FAULT. The FSM evaluates every clock using the registered level and fault.
  - NORMAL → FILLING when level ≤ `LOW_MARK`.
  - FILLING → NORMAL when level ≥ `HIGH_MARK`.
  - Levels strictly between `LOW_MARK` and `HIGH_MARK` keep the current state (hysteresis).
  - Any state → FAULT when `probe_fault`=1. Fault takes priority over the mark comparisons.
  - FAULT → NORMAL when `probe_fault`=0. The mark comparisons are applied from the following cycle.
- **Outputs by state:**
  - `filling_condition` = 1 only in FILLING.
  - `watering_condition` = 1 when not in FAULT and level > `DRY_MARK`.
  - A tank in FILLING may still water if level > `DRY_MARK`.
- **Reset:** every register clears. This covers both synchroniser stages, debounced values, counters, `water_level`=0, `probe_fault`=0, state NORMAL, `watering_condition`=0 and `filling_condition`=0.
  - The cleared level of 0 makes the FSM enter FILLING on the first clock after reset.
  - Reset mid-debounce discards the partial count.

## Timing
- **Probe to debounced:** a raw change reaches the synchroniser output 2 clocks later. The debounced value flips on the `DEBOUNCE_SAMPLES`-th subsequent tick on which the synchronised value still differs.
- **Debounced to outputs:**
  - Debounced flip at edge T: `water_level` and `probe_fault` update at T+1.
  - FSM state, `watering_condition` and `filling_condition` update at T+2.
- **Glitches:** a probe glitch shorter than `DEBOUNCE_SAMPLES` ticks produces no output change. Any agreeing tick restarts its count.
- **Multiple probes:** several probes may flip on the same tick. The code check sees the combined vector, so there is no transient fault from the ordering of flips.
- **Tick during reset:** `sample_tick` asserted during reset is ignored.

## Configuration
- `STICKY_FAULT_EN` defined: FAULT is absorbing.
  - Once entered, the state stays FAULT and `probe_fault` stays 1 until `reset`, even after the probe code becomes legal again.
  - `water_level` still tracks legal codes.
- `STICKY_FAULT_EN` undefined: FAULT recovers to NORMAL as described in Operation.

## Structure
- Shared package `irrigation_pkg` holds:
  - the FSM state enum (NORMAL, FILLING, FAULT);
  - `PROBE_COUNT` = 7;
  - `LEVEL_WIDTH` = 3.
- Sub-module `probe_debouncer`: one probe's synchroniser, counter and debounced register, parameterised by `DEBOUNCE_SAMPLES`. Instantiated 7 times with a generate loop.
- The code check, level count and FSM live in the top module.

## Test plan
- **Reset:** reset with `probe`=7'b0000000, then release. Expected: level 0, FILLING, `filling_condition`=1 and `watering_condition`=0 from the first clock after release.
- **Fill and hysteresis:** ramp the probes up 0→7 ones, holding each step 5 ticks. Expected:
  - `filling_condition` stays 1 until level 6, then drops 2 clocks after the 6th probe flips.
  - `watering_condition` rises at level 2.
- **Drain:** drain the probes 7→0. Expected:
  - `filling_condition` stays 0 at levels 5, 4 and 3, and rises at level 2;
  - `watering_condition` drops at level 1.
- **Debounce:** a 3-tick pulse on `probe[0]` with `DEBOUNCE_SAMPLES`=4 gives no output change. A 4-tick pulse changes level 0→1 on the 4th tick + 1 clock.
- **Fault:** debounced probes 7'b0000101. Expected: `probe_fault`=1, level holds at its prior value 1, both conditions 0. After restoring 7'b0000111, the state returns to NORMAL and level becomes 3. With `STICKY_FAULT_EN` defined, `probe_fault` stays 1 until reset.
- **Reset mid-debounce:** assert reset after 3 of 4 disagreeing ticks. After release, 4 fresh ticks are needed before the flip.
